// File: rtl/vjtag_pkg.sv
// Shared definitions for the virtual-JTAG register bank: IR codes, decoded op
// type and the STATUS capture word layout.
package vjtag_pkg;

  localparam int unsigned IR_BYPASS    = 0;
  localparam int unsigned IR_ADDR      = 1;
  localparam int unsigned IR_WRITE     = 2;
  localparam int unsigned IR_READ      = 3;
  localparam int unsigned IR_WRITE_INC = 4;
  localparam int unsigned IR_STATUS    = 5;

  // Widest data chain the status helper can lay out.
  localparam int unsigned STAT_MAX_W = 64;

  typedef enum logic [2:0] {
    OP_BYPASS    = 3'd0,
    OP_ADDR      = 3'd1,
    OP_WRITE     = 3'd2,
    OP_READ      = 3'd3,
    OP_WRITE_INC = 3'd4,
    OP_STATUS    = 3'd5
  } vjtag_op_e;

  // Status word: error flag in the chain MSB, write count in the bits below it.
  function automatic logic [STAT_MAX_W-1:0] status_word(
    input logic                  err_flag,
    input logic [STAT_MAX_W-1:0] wr_cnt,
    input int unsigned           dw
  );
    logic [STAT_MAX_W-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < STAT_MAX_W; i++) begin
      if (i + 1 < dw)       w[i] = wr_cnt[i];
      else if (i + 1 == dw) w[i] = err_flag;
    end
    return w;
  endfunction

endpackage

// File: rtl/vjtag_reg_bank_if.sv
// Virtual-JTAG scan signals between the vjtag megafunction (master) and the
// register bank (slave).
interface vjtag_reg_bank_if #(
  parameter int unsigned IR_W = 3
);
  logic [IR_W-1:0] ir_in;
  logic            tdi;
  logic            v_cdr;
  logic            v_sdr;
  logic            v_udr;
  logic            tdo;

  modport master (output ir_in, tdi, v_cdr, v_sdr, v_udr, input tdo);
  modport slave  (input ir_in, tdi, v_cdr, v_sdr, v_udr, output tdo);
endinterface

// File: rtl/vjtag_shift_chain.sv
// Width-W capture/shift register, shifting LSB first; q[0] is the serial-out tap.
module vjtag_shift_chain #(
  parameter int unsigned W = 8
) (
  input  logic         tck,
  input  logic         rst_n,
  input  logic         cap_en,
  input  logic [W-1:0] cap_val,
  input  logic         shift_en,
  input  logic         tdi,
  output logic [W-1:0] q
);

  logic [W-1:0] sr_q, sr_d, shifted;

  generate
    if (W == 1) begin : g_one
      assign shifted = tdi;
    end else begin : g_wide
      assign shifted = {tdi, sr_q[W-1:1]};
    end
  endgenerate

  // Capture takes priority over shift; the parent already masks both on update.
  always_comb begin
    sr_d = sr_q;
    if (cap_en)        sr_d = cap_val;
    else if (shift_en) sr_d = shifted;
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign q = sr_q;

endmodule

// File: rtl/vjtag_reg_bank.sv
// Virtual-JTAG register bank: addressable host-writable registers with read-back,
// auto-increment writes, bypass and a sticky status/error register.
module vjtag_reg_bank
  import vjtag_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IR_W     = 3
) (
  input  logic                       tck,
  input  logic                       rst_n,
  input  logic [IR_W-1:0]            ir_in,
  input  logic                       tdi,
  input  logic                       v_cdr,
  input  logic                       v_sdr,
  input  logic                       v_udr,
  output logic                       tdo,
  output logic [NUM_REGS*DATA_W-1:0] data_regs,
  output logic [NUM_REGS-1:0]        wr_stb,
  output logic                       err
);

  localparam int unsigned ADDR_W = $clog2(NUM_REGS);
  localparam int unsigned AW1    = ADDR_W + 1;
  localparam int unsigned CNT_W  = DATA_W - 1;
  localparam logic [AW1-1:0] NREGS_C = AW1'(NUM_REGS);

  vjtag_op_e op;

  logic [DATA_W-1:0] data_sr, data_cap, rd_data;
  logic [ADDR_W-1:0] addr_sr;
  logic [0:0]        byp_sr;
  logic              cap_en, sh_en, data_act, addr_act, byp_act, addr_ok;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Unused instruction codes fall back to BYPASS.
  always_comb begin
    op = OP_BYPASS;
    if      (ir_in == IR_W'(IR_ADDR))      op = OP_ADDR;
    else if (ir_in == IR_W'(IR_WRITE))     op = OP_WRITE;
    else if (ir_in == IR_W'(IR_READ))      op = OP_READ;
    else if (ir_in == IR_W'(IR_WRITE_INC)) op = OP_WRITE_INC;
    else if (ir_in == IR_W'(IR_STATUS))    op = OP_STATUS;
  end

  // Update beats capture beats shift when strobes overlap.
  assign cap_en   = v_cdr & ~v_udr;
  assign sh_en    = v_sdr & ~v_udr & ~v_cdr;
  assign byp_act  = (op == OP_BYPASS);
  assign addr_act = (op == OP_ADDR);
  assign data_act = !byp_act && !addr_act;
  assign addr_ok  = {1'b0, addr_q} < NREGS_C;

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_W'(i)) rd_data = regs_q[i];
    end
  end

  always_comb begin
    data_cap = '0;
    case (op)
      OP_READ:   data_cap = rd_data;
      OP_STATUS: data_cap = DATA_W'(status_word(err_q, STAT_MAX_W'(cnt_q), DATA_W));
      default:   data_cap = '0;
    endcase
  end

  vjtag_shift_chain #(.W(DATA_W)) u_data_chain (
    .tck      (tck),
    .rst_n    (rst_n),
    .cap_en   (cap_en & data_act),
    .cap_val  (data_cap),
    .shift_en (sh_en & data_act),
    .tdi      (tdi),
    .q        (data_sr)
  );

  vjtag_shift_chain #(.W(ADDR_W)) u_addr_chain (
    .tck      (tck),
    .rst_n    (rst_n),
    .cap_en   (cap_en & addr_act),
    .cap_val  (addr_q),
    .shift_en (sh_en & addr_act),
    .tdi      (tdi),
    .q        (addr_sr)
  );

  vjtag_shift_chain #(.W(1)) u_byp_chain (
    .tck      (tck),
    .rst_n    (rst_n),
    .cap_en   (cap_en & byp_act),
    .cap_val  (1'b0),
    .shift_en (sh_en & byp_act),
    .tdi      (tdi),
    .q        (byp_sr)
  );

  // Update-DR commit: register writes, address moves and status bookkeeping.
  always_comb begin
    regs_d   = regs_q;
    wr_stb_d = '0;
    addr_d   = addr_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    if (v_udr) begin
      case (op)
        OP_ADDR: addr_d = addr_sr;
        OP_WRITE, OP_WRITE_INC: begin
          if (addr_ok) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (addr_q == ADDR_W'(i)) begin
                regs_d[i]   = data_sr;
                wr_stb_d[i] = 1'b1;
              end
            end
            if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
            if (op == OP_WRITE_INC) begin
              addr_d = (addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : addr_q + ADDR_W'(1);
            end
          end else begin
            err_d = 1'b1;
            if (op == OP_WRITE_INC) addr_d = '0;
          end
        end
        OP_READ: if (!addr_ok) err_d = 1'b1;
        OP_STATUS: begin
          err_d = 1'b0;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      regs_q   <= '{default: '0};
      wr_stb_q <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      regs_q   <= regs_d;
      wr_stb_q <= wr_stb_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    case (op)
      OP_BYPASS: tdo = byp_sr[0];
      OP_ADDR:   tdo = addr_sr[0];
      default:   tdo = data_sr[0];
    endcase
  end

  always_comb begin
    data_regs = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      data_regs[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  assign wr_stb = wr_stb_q;
  assign err    = err_q;

endmodule
